// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: fetch FSM encoding
// and the default branch-history-table index width.
package inst_fetch_ctrl_pkg;

    localparam int BHT_IDX_BIT_DEF = 4;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_FETCH,
        FS_READY,
        FS_STALL,
        FS_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Instruction-cache request/response bus between the fetch controller (master)
// and the icache (slave).
interface inst_fetch_ctrl_if;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_valid;
    logic [31:0] icache_data;

    modport master (output icache_req, icache_addr, input icache_valid, icache_data);
    modport slave  (input icache_req, icache_addr, output icache_valid, icache_data);
endinterface

// File: rtl/inst_fetch_ctrl_bht.sv
// Branch history table: 2^IDX_BIT 2-bit saturating counters, reset weakly
// not-taken. Read is combinational from registered state.
module bht
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int IDX_BIT = BHT_IDX_BIT_DEF
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [IDX_BIT-1:0] rd_idx,
    output logic               rd_taken,
    input  logic               upd_en,
    input  logic [IDX_BIT-1:0] upd_idx,
    input  logic               upd_taken
);
    localparam int ENTRIES = 1 << IDX_BIT;

    logic [ENTRIES-1:0][1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (upd_en) begin
            if (upd_taken && cnt_q[upd_idx] != 2'b11)
                cnt_d[upd_idx] = cnt_q[upd_idx] + 2'd1;
            else if (!upd_taken && cnt_q[upd_idx] != 2'b00)
                cnt_d[upd_idx] = cnt_q[upd_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) cnt_q <= {ENTRIES{2'b01}};
        else           cnt_q <= cnt_d;
    end

    // An update this cycle is only visible on rd_taken next cycle.
    assign rd_taken = cnt_q[rd_idx][1];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: one outstanding icache request, holds the
// fetched word for the decoder, handles ROB flush/redirect.
// Optional branch prediction is enabled by defining BHT_PREDICT_EN.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          BHT_IDX_BIT = BHT_IDX_BIT_DEF
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               rdy_in,
    inst_fetch_ctrl_if.master  ic,
    output logic               to_decoder,
    output logic [31:0]        pc,
    output logic [31:0]        inst,
    output logic               predict,
    input  logic               dec_accept,
    input  logic [31:0]        next_pc,
    input  logic               flush_in,
    input  logic [31:0]        flush_pc,
    input  logic               bht_upd_en,
    input  logic [31:0]        bht_upd_pc,
    input  logic               bht_upd_taken
);
    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic         to_dec_q, to_dec_d;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        if (rdy_in) begin
            case (state_q)
                FS_IDLE: begin
                    if (flush_in) fetch_pc_d = flush_pc;
                    else          state_d    = FS_FETCH;
                end
                FS_FETCH: begin
                    // A flush orphans the in-flight response; drain it unless it is arriving now.
                    if (flush_in) begin
                        fetch_pc_d = flush_pc;
                        state_d    = ic.icache_valid ? FS_IDLE : FS_DRAIN;
                    end else if (ic.icache_valid) begin
                        inst_d  = ic.icache_data;
                        pc_d    = fetch_pc_q;
                        state_d = FS_READY;
                    end
                end
                FS_READY: begin
                    if (flush_in) begin
                        fetch_pc_d = flush_pc;
                        state_d    = FS_IDLE;
                    end else if (dec_accept) begin
                        if (next_pc != pc_q) begin
                            fetch_pc_d = next_pc;
                            state_d    = FS_IDLE;
                        end else begin
                            state_d = FS_STALL;
                        end
                    end
                end
                FS_STALL: begin
                    if (flush_in) begin
                        fetch_pc_d = flush_pc;
                        state_d    = FS_IDLE;
                    end
                end
                FS_DRAIN: begin
                    if (flush_in)          fetch_pc_d = flush_pc;
                    if (ic.icache_valid)   state_d    = FS_IDLE;
                end
                default: state_d = FS_IDLE;
            endcase
        end
        to_dec_d = (state_d == FS_READY);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= FS_IDLE;
            fetch_pc_q <= RESET_PC;
            pc_q       <= '0;
            inst_q     <= '0;
            to_dec_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            to_dec_q   <= to_dec_d;
        end
    end

    // Request goes out in the IDLE cycle itself so the first fetch after reset is not delayed.
    assign ic.icache_req  = rst_n_in & rdy_in & ~flush_in & (state_q == FS_IDLE);
    assign ic.icache_addr = ic.icache_req ? fetch_pc_q : 32'h0;

    assign to_decoder = to_dec_q;
    assign pc         = pc_q;
    assign inst       = inst_q;

`ifdef BHT_PREDICT_EN
    logic bht_taken;

    bht #(.IDX_BIT(BHT_IDX_BIT)) u_bht (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .rd_idx    (pc_q[BHT_IDX_BIT:1]),
        .rd_taken  (bht_taken),
        .upd_en    (bht_upd_en & rdy_in),
        .upd_idx   (bht_upd_pc[BHT_IDX_BIT:1]),
        .upd_taken (bht_upd_taken)
    );

    assign predict = bht_taken;
`else
    assign predict = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{bht_upd_en, bht_upd_pc, bht_upd_taken, 4'(BHT_IDX_BIT)};

endmodule
